serial_negator_framed: RTL and testbench

- Parametrised, word-framed successor to the single-bit serial two's-complement FSM.
- Accepts an LSB-first serial bit stream in fixed words of WIDTH bits and emits the transformed stream LSB-first.
- The transform is selectable per word: pass-through, one's complement or two's complement.
- Adds valid qualification, automatic word framing with last-bit marking, per-word mode latching and two's-complement overflow detection.
- Sits between serial arithmetic units (serial adders/subtractors) in the datapath.

---
 rtl/serial_negator_framed.sv | 82 ++++++++
 tb/tb_serial_negator_framed.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_negator_framed.sv
// Word-framed LSB-first serial transform (pass / one's / two's complement) with overflow flag.
// One-cycle registered latency; no backpressure, every out_valid cycle must be accepted.
module serial_negator_framed #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_first,
  output logic       out_last,
  output logic       ovf
);

  localparam logic [1:0] MODE_ONES = 2'b01;
  localparam logic [1:0] MODE_TWOS = 2'b10;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bit_cnt;
  logic [1:0]       mode_lat;
  logic             seen_one;
  logic             low_zero;

  logic             is_first;
  logic             is_last;
  logic [1:0]       eff_mode;
  logic             seen_eff;
  logic             low_zero_eff;
  logic             xf_bit;
  logic             ovf_nxt;

  // Word-start bits use the live mode and fresh history, independent of the previous word.
  always_comb begin
    is_first     = (bit_cnt == '0);
    is_last      = (bit_cnt == LAST_IDX);
    eff_mode     = is_first ? mode : mode_lat;
    seen_eff     = is_first ? 1'b0 : seen_one;
    low_zero_eff = is_first ? 1'b1 : low_zero;
    xf_bit       = in_bit;
    case (eff_mode)
      MODE_ONES: xf_bit = ~in_bit;
      MODE_TWOS: xf_bit = seen_eff ? ~in_bit : in_bit;
      default:   xf_bit = in_bit;
    endcase
    ovf_nxt = is_last & (eff_mode == MODE_TWOS) & low_zero_eff & in_bit;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      mode_lat  <= 2'b00;
      seen_one  <= 1'b0;
      low_zero  <= 1'b1;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else if (in_valid) begin
      bit_cnt   <= is_last ? '0 : bit_cnt + 1'b1;
      if (is_first) mode_lat <= mode;
      seen_one  <= seen_eff | in_bit;
      low_zero  <= low_zero_eff & ~in_bit;
      out_valid <= 1'b1;
      out_bit   <= xf_bit;
      out_first <= is_first;
      out_last  <= is_last;
      ovf       <= ovf_nxt;
    end else begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_negator_framed.sv
// Bench for serial_negator_framed (WIDTH=8): directed table, reset corner case, random words vs word-level model.
module tb_serial_negator_framed;

  logic       clk;
  logic       reset_n;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_bit;
  logic       out_valid;
  logic       out_bit;
  logic       out_first;
  logic       out_last;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  serial_negator_framed #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] data;
    bit         gap;
    bit         midchg;
    logic [1:0] mode2;
    logic [7:0] exp_word;
    logic       exp_ovf;
  } vec_t;

  // Expected words in arrival order: {ovf, word}
  logic [8:0] expq[$];

  // Word-level reference: whole-word arithmetic on the data value.
  function automatic logic [8:0] model(input logic [1:0] m, input logic [7:0] d);
    logic [7:0] r;
    case (m)
      2'b01:   r = ~d;
      2'b10:   r = 8'(9'd256 - {1'b0, d});
      default: r = d;
    endcase
    return {(m == 2'b10) && (d == 8'h80), r};
  endfunction

  // Monitor: expects out_valid one cycle after an accepted input bit, rebuilds words.
  logic prev_v   = 1'b0;
  logic prev_rst = 1'b0;
  int   mcnt     = 0;
  logic [7:0] mword;

  always @(posedge clk) begin
    prev_v   = in_valid && reset_n;
    prev_rst = reset_n;
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (!prev_rst) mcnt = 0;
    checks++;
    if (out_valid !== prev_v) begin
      failures++;
      $display("FAIL valid_latency: got %b want %b at %0t", out_valid, prev_v, $time);
    end
    if (out_valid !== 1'b1) begin
      checks++;
      if ({out_bit, out_first, out_last, ovf} !== 4'b0000) begin
        failures++;
        $display("FAIL idle_zero: bit/first/last/ovf got %b%b%b%b want 0000 at %0t",
                 out_bit, out_first, out_last, ovf, $time);
      end
    end else begin
      checks++;
      if (out_first !== (mcnt == 0) || out_last !== (mcnt == 7) || (mcnt != 7 && ovf !== 1'b0)) begin
        failures++;
        $display("FAIL flags: idx %0d got first=%b last=%b ovf=%b want first=%b last=%b at %0t",
                 mcnt, out_first, out_last, ovf, (mcnt == 0), (mcnt == 7), $time);
      end
      mword[mcnt] = out_bit;
      if (mcnt == 7) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected: got %h ovf=%b want none", mword, ovf);
        end else begin
          e = expq.pop_front();
          if (mword !== e[7:0] || ovf !== e[8]) begin
            failures++;
            $display("FAIL word: got %h ovf=%b want %h ovf=%b at %0t", mword, ovf, e[7:0], e[8], $time);
          end
        end
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end
  end

  // Drives one word starting at posedge+1; leaves inputs idle without consuming a cycle.
  task automatic send_word(input logic [1:0] m, input logic [7:0] d, input bit gap,
                           input bit midchg, input logic [1:0] m2);
    for (int i = 0; i < 8; i++) begin
      mode     = (midchg && i >= 4) ? m2 : m;
      in_bit   = d[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (gap) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
        mode     = 2'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b10, 8'h0C, 1'b0, 1'b0, 2'b00, 8'hF4, 1'b0};
    vecs[1] = '{2'b10, 8'h80, 1'b0, 1'b0, 2'b00, 8'h80, 1'b1};
    vecs[2] = '{2'b10, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
    vecs[3] = '{2'b01, 8'h5A, 1'b0, 1'b0, 2'b00, 8'hA5, 1'b0};
    vecs[4] = '{2'b00, 8'h5A, 1'b0, 1'b1, 2'b10, 8'h5A, 1'b0};
    vecs[5] = '{2'b10, 8'h01, 1'b1, 1'b0, 2'b00, 8'hFF, 1'b0};
    vecs[6] = '{2'b11, 8'h80, 1'b0, 1'b0, 2'b00, 8'h80, 1'b0};
    vecs[7] = '{2'b01, 8'h80, 1'b0, 1'b1, 2'b10, 8'h7F, 1'b0};

    reset_n  = 1'b0;
    mode     = 2'b00;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_bit, out_first, out_last, ovf} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_state: got %b want 00000", {out_valid, out_bit, out_first, out_last, ovf});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      expq.push_back({vecs[i].exp_ovf, vecs[i].exp_word});
      send_word(vecs[i].mode, vecs[i].data, vecs[i].gap, vecs[i].midchg, vecs[i].mode2);
    end

    // Reset mid-word, with a valid bit offered during the reset cycle (must be dropped).
    mode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      in_bit   = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    in_bit  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_bit, out_first, out_last, ovf} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_midword: got %b want 00000", {out_valid, out_bit, out_first, out_last, ovf});
    end
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    @(posedge clk); #1;
    expq.push_back({1'b0, 8'hFD});
    send_word(2'b10, 8'h03, 1'b0, 1'b0, 2'b00);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] m;
      logic [7:0] d;
      m = 2'($urandom);
      d = (n % 10 == 0) ? 8'h80 : 8'($urandom);
      expq.push_back(model(m, d));
      send_word(m, d, ($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0 || mcnt != 0) begin
      failures++;
      $display("FAIL drain: pending words %0d partial bits %0d want 0 and 0", expq.size(), mcnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
